// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: slot allocator and per-frame position sequencer for the obstacle table
module obstacle_scheduler #(
    parameter int          NUM_SLOTS = 10,
    parameter logic [10:0] SPAWN_POS = 11'd1023,
    parameter logic [10:0] MIN_GAP   = 11'd160
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   game_reset,
    input  logic                   frame_trigger,
    input  logic [3:0]             speed,
    input  logic                   spawn_valid,
    input  logic [1:0]             spawn_lane,
    input  logic [1:0]             spawn_type,
    output logic                   spawn_ready,
    output logic [16*NUM_SLOTS-1:0] obstacles_out,
    output logic [3:0]             active_count,
    output logic                   frame_done,
    output logic                   frame_overrun
);
    typedef enum logic {IDLE, WALK} state_t;

    localparam logic [10:0] BLOCK_POS = SPAWN_POS - MIN_GAP;
    localparam logic [3:0]  LAST_IDX  = 4'(NUM_SLOTS - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  speed_q, speed_d;
    logic [3:0]  count_q, count_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic [15:0] slot_q [NUM_SLOTS];
    logic [15:0] slot_d [NUM_SLOTS];
    logic        any_free, lane_blocked;
    logic [3:0]  free_idx;
    logic [15:0] cur;
    logic [10:0] cur_pos;

    assign cur     = slot_q[idx_q];
    assign cur_pos = cur[13:3];

    // lowest free slot and same-lane spacing check against the requested lane
    always_comb begin
        any_free     = 1'b0;
        free_idx     = '0;
        lane_blocked = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_q[i][0]) begin
                any_free = 1'b1;
                free_idx = 4'(i);
            end
            if (slot_q[i][0] && slot_q[i][2:1] == spawn_lane && slot_q[i][13:3] > BLOCK_POS)
                lane_blocked = 1'b1;
        end
    end

    assign spawn_ready = (state_q == IDLE) && !frame_trigger && any_free &&
                         (spawn_lane != 2'd3) && !lane_blocked;

    // next state: frame start, spawn allocation in IDLE, one slot per cycle in WALK
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        speed_d   = speed_q;
        count_d   = count_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        slot_d    = slot_q;
        if (state_q == IDLE) begin
            if (frame_trigger) begin
                state_d = WALK;
                idx_d   = '0;
                speed_d = speed;
            end else if (spawn_valid && spawn_ready) begin
                slot_d[free_idx] = {spawn_type, SPAWN_POS, spawn_lane, 1'b1};
                count_d          = count_q + 4'd1;
            end
        end else begin
            overrun_d = overrun_q | frame_trigger;
            if (cur[0] && cur_pos <= {7'd0, speed_q}) begin
                slot_d[idx_q] = {cur[15:14], 11'd0, cur[2:1], 1'b0};
                count_d       = count_q - 4'd1;
            end else if (cur[0]) begin
                slot_d[idx_q] = {cur[15:14], cur_pos - {7'd0, speed_q}, cur[2:1], 1'b1};
            end
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    // state registers; game_reset clears everything except the sticky overrun flag
    always_ff @(posedge clk_in) begin
        if (rst_in || game_reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            speed_q   <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= rst_in ? 1'b0 : overrun_q;
            slot_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            speed_q   <= speed_d;
            count_q   <= count_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            slot_q    <= slot_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
        assign obstacles_out[16*g +: 16] = slot_q[g];
    end

    assign active_count  = count_q;
    assign frame_done    = done_q;
    assign frame_overrun = overrun_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: directed and random stimulus checked against a slot-table reference model
module tb_obstacle_scheduler;
    localparam int N = 10;
    localparam int BLOCK = 1023 - 160;

    logic           clk_in = 1'b0;
    logic           rst_in, game_reset, frame_trigger, spawn_valid;
    logic [3:0]     speed;
    logic [1:0]     spawn_lane, spawn_type;
    logic           spawn_ready, frame_done, frame_overrun;
    logic [16*N-1:0] obstacles_out;
    logic [3:0]     active_count;

    int n_checks = 0;
    int n_fail = 0;

    int m_type [N];
    int m_pos  [N];
    int m_lane [N];
    bit m_act  [N];
    bit m_walk, m_done, m_over;
    int m_widx, m_spd;

    obstacle_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in), .game_reset(game_reset),
        .frame_trigger(frame_trigger), .speed(speed),
        .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_type(spawn_type),
        .spawn_ready(spawn_ready), .obstacles_out(obstacles_out),
        .active_count(active_count), .frame_done(frame_done), .frame_overrun(frame_overrun)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [16*N-1:0] got, input logic [16*N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < N; i++) begin
            m_type[i] = 0; m_pos[i] = 0; m_lane[i] = 0; m_act[i] = 0;
        end
        m_walk = 0; m_widx = 0; m_done = 0;
    endfunction

    function automatic bit m_ready(bit t, int ln);
        bit free = 0;
        bit blocked = 0;
        for (int i = 0; i < N; i++) begin
            if (!m_act[i]) free = 1;
            else if (m_lane[i] == ln && m_pos[i] > BLOCK) blocked = 1;
        end
        return !m_walk && !t && ln != 3 && free && !blocked;
    endfunction

    function automatic logic [16*N-1:0] m_vec();
        logic [16*N-1:0] v = '0;
        for (int i = 0; i < N; i++)
            v[16*i +: 16] = {m_type[i][1:0], m_pos[i][10:0], m_lane[i][1:0], m_act[i]};
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_act[i]);
        return c;
    endfunction

    function automatic logic [15:0] slot(int i);
        return obstacles_out[16*i +: 16];
    endfunction

    task automatic step(input bit r, input bit g, input bit t, input int sp, input bit v,
                        input int ln, input int ty, output bit acc);
        bit rdy;
        bit found = 0;
        @(negedge clk_in);
        rst_in = r; game_reset = g; frame_trigger = t; speed = 4'(sp);
        spawn_valid = v; spawn_lane = 2'(ln); spawn_type = 2'(ty);
        #1;
        rdy = m_ready(t, ln);
        check("spawn_ready", spawn_ready, rdy);
        check("obstacles", obstacles_out, m_vec());
        check("active_count", active_count, m_count());
        check("frame_done", frame_done, m_done);
        check("frame_overrun", frame_overrun, m_over);
        acc = v && spawn_ready;
        @(posedge clk_in);
        if (r) begin
            m_clear(); m_over = 0;
        end else if (g) begin
            m_clear();
        end else begin
            m_done = 0;
            if (m_walk) begin
                if (m_act[m_widx]) begin
                    if (m_pos[m_widx] <= m_spd) begin
                        m_act[m_widx] = 0; m_pos[m_widx] = 0;
                    end else begin
                        m_pos[m_widx] -= m_spd;
                    end
                end
                if (t) m_over = 1;
                if (m_widx == N - 1) begin
                    m_walk = 0; m_done = 1;
                end else begin
                    m_widx++;
                end
            end else if (t) begin
                m_walk = 1; m_widx = 0; m_spd = sp;
            end else if (v && rdy) begin
                for (int i = 0; i < N; i++)
                    if (!m_act[i] && !found) begin
                        found = 1;
                        m_act[i] = 1; m_pos[i] = 1023; m_lane[i] = ln; m_type[i] = ty;
                    end
            end
        end
    endtask

    task automatic frame_v(input int sp, input bit v, input int ln, input int ty, output bit acc);
        bit a;
        acc = 0;
        step(0, 0, 1, sp, v, ln, ty, a);
        acc |= a;
        repeat (11) begin
            step(0, 0, 0, 0, v, ln, ty, a);
            acc |= a;
        end
    endtask

    task automatic frames(input int n, input int sp);
        bit a;
        repeat (n) frame_v(sp, 0, 0, 0, a);
    endtask

    task automatic spawn(input int ln, input int ty);
        bit a = 0;
        int k = 0;
        while (!a && k < 40) begin
            step(0, 0, 0, 0, 1, ln, ty, a);
            k++;
        end
        check("spawn_accepted", a, 1);
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, a);
    endtask

    initial begin
        bit a;
        bit v = 0;
        int f, ln, ty, age;
        logic [15:0] s;
        rst_in = 1; game_reset = 0; frame_trigger = 0; speed = 0;
        spawn_valid = 0; spawn_lane = 0; spawn_type = 0;
        repeat (2) @(posedge clk_in);
        m_clear(); m_over = 0;
        step(1, 0, 0, 0, 0, 0, 0, a);
        #2;
        check("rst_obstacles", obstacles_out, 0);
        check("rst_count", active_count, 0);
        check("rst_overrun", frame_overrun, 0);

        spawn(1, 2);
        #2;
        check("spawn_slot0", slot(0), {2'd2, 11'd1023, 2'd1, 1'b1});
        check("spawn_count", active_count, 1);
        check("spawn_others_zero", obstacles_out >> 16, 0);

        step(1, 0, 0, 0, 0, 0, 0, a);
        spawn(0, 0);
        step(0, 0, 0, 0, 1, 0, 1, a);
        check("same_lane_held", a, 0);
        f = 0; a = 0;
        while (!a && f < 20) begin
            f++;
            frame_v(15, 1, 0, 1, a);
        end
        check("frames_to_accept", f, 11);
        #2;
        s = slot(0);
        check("gap_pos", s[13:3], 858);
        check("gap_slot1", slot(1), {2'd1, 11'd1023, 2'd0, 1'b1});

        step(1, 0, 0, 0, 0, 0, 0, a);
        spawn(0, 1);
        frames(67, 15);
        frames(1, 13);
        #2;
        s = slot(0);
        check("pre_retire_pos", s[13:3], 5);
        step(0, 0, 1, 7, 0, 0, 0, a);
        idle(9);
        #2;
        check("done_not_early", frame_done, 0);
        idle(1);
        #2;
        check("done_at_T11", frame_done, 1);
        s = slot(0);
        check("retired_active", s[0], 0);
        check("retired_pos", s[13:3], 0);
        check("retired_count", active_count, 0);
        idle(1);

        step(1, 0, 0, 0, 0, 0, 0, a);
        spawn(0, 0); spawn(1, 1); spawn(2, 2);
        frames(11, 15);
        spawn(0, 3);
        frames(11, 15);
        spawn(0, 0); spawn(1, 1); spawn(2, 2);
        frames(11, 15);
        spawn(0, 1); spawn(1, 2); spawn(2, 3);
        step(0, 0, 0, 0, 1, 1, 0, a);
        check("full_ready", a, 0);
        check("full_count", active_count, 10);
        frames(35, 15);
        frames(1, 3);
        #2;
        check("three_retired", active_count, 7);
        spawn(0, 0); spawn(1, 1); spawn(2, 2);
        frames(11, 15);
        #2;
        s = slot(3);
        check("slot3_retired", s[0], 0);
        check("nine_left", active_count, 9);
        spawn(1, 2);
        #2;
        check("refill_slot3", slot(3), {2'd2, 11'd1023, 2'd1, 1'b1});

        step(1, 0, 0, 0, 0, 0, 0, a);
        spawn(0, 0); spawn(1, 1); spawn(2, 2);
        step(0, 0, 1, 5, 0, 0, 0, a);
        idle(3);
        step(0, 0, 1, 9, 0, 0, 0, a);
        idle(7);
        #2;
        check("overrun_set", frame_overrun, 1);
        s = slot(0);
        check("overrun_single_move", s[13:3], 1018);

        frames(11, 15);
        spawn(0, 1); spawn(1, 2); spawn(2, 3);
        #2;
        check("six_active", active_count, 6);
        step(0, 0, 1, 3, 0, 0, 0, a);
        idle(4);
        step(0, 1, 0, 0, 0, 0, 0, a);
        #2;
        check("greset_slots", obstacles_out, 0);
        check("greset_count", active_count, 0);
        check("greset_keeps_overrun", frame_overrun, 1);
        step(0, 0, 0, 0, 1, 0, 0, a);
        check("greset_idle_accept", a, 1);
        step(1, 0, 0, 0, 0, 0, 0, a);
        #2;
        check("rst_clears_overrun", frame_overrun, 0);

        for (int k = 0; k < 3000; k++) begin
            bit r = ($urandom % 1000) == 0;
            bit g = ($urandom % 300) == 0;
            bit t = ($urandom % 10) == 0;
            if (!v && ($urandom % 2) == 1) begin
                v = 1;
                ln = ($urandom % 8 == 0) ? 3 : int'($urandom % 3);
                ty = int'($urandom % 4);
                age = 0;
            end
            step(r, g, t, int'($urandom % 16), v, ln, ty, a);
            age++;
            if (a || age > 60) v = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Slot manager and per-frame sequencer for the obstacle table consumed by track drawing and death detection. Accepts spawn requests from the obstacle generator through a valid/ready handshake and allocates each to the lowest free slot. On every frame trigger it walks all slots, advancing active obstacles toward the player and retiring those that pass position 0. It is the single writer of the obstacle table and sits between the obstacle generator and the track drawer and death checker.

## Interface
- NUM_SLOTS, 10, number of obstacle slots (2..15)
- SPAWN_POS, 11'd1023, position written into a newly allocated slot
- MIN_GAP, 11'd160, minimum same-lane distance from SPAWN_POS before another spawn is accepted in that lane

- clk_in  input  1  system clock (65 MHz pixel clock domain)
- rst_in  input  1  synchronous, active-high reset
- game_reset  input  1  synchronous clear of all slots; same effect as rst_in except it does not clear frame_overrun
- frame_trigger  input  1  one-cycle pulse, once per video frame
- speed  input  4  position decrement per frame; sampled on accepted frame_trigger
- spawn_valid  input  1  spawn request present
- spawn_lane  input  2  requested lane (0..2; 3 is rejected)
- spawn_type  input  2  sprite type
- spawn_ready  output  1  spawn accepted this cycle when spawn_valid && spawn_ready
- obstacles_out  output  16*NUM_SLOTS  slot i at [16i+15:16i]: [15:14] type, [13:3] position, [2:1] lane, [0] active
- active_count  output  4  number of active slots
- frame_done  output  1  one-cycle pulse when a frame walk completes
- frame_overrun  output  1  sticky; set when frame_trigger arrives outside IDLE

## Operation
- FSM states: IDLE, WALK.
- IDLE -> WALK on frame_trigger: latch speed into speed_q and clear slot index idx to 0.
- In WALK, one slot per cycle at idx:
  - If the slot is inactive, no change.
  - If the slot is active and position <= speed_q: clear active, set position to 0, decrement active_count.
  - Otherwise position <= position - speed_q, using 11-bit unsigned arithmetic with no wrap by construction.
- WALK -> IDLE after idx == NUM_SLOTS-1. frame_done pulses on the cycle after that last slot update, with the FSM back in IDLE.
- spawn_ready = (state == IDLE) && !frame_trigger && any_free && spawn_lane != 3 && !lane_blocked.
  - lane_blocked: some active slot has lane == spawn_lane and position > SPAWN_POS - MIN_GAP.
  - spawn_ready depends combinationally on spawn_lane. Requesters must hold spawn_lane and spawn_type stable while spawn_valid is high.
- On accept, the lowest-index free slot gets {spawn_type, SPAWN_POS, spawn_lane, 1}. active_count increments.
- If frame_trigger and spawn_valid are asserted in the same IDLE cycle, the trigger wins and the spawn waits (ready = 0).
- If frame_trigger arrives in WALK, it is ignored and frame_overrun is set. The current walk continues unaffected.
- With all slots active, spawn_ready stays 0 and the request waits indefinitely. No drop, no error.
- speed = 0: walk runs and nothing moves or retires.

## Timing
- Reset (rst_in or game_reset): every slot = 16'h0000, active_count = 0, state IDLE, idx = 0, frame_done = 0. rst_in also clears frame_overrun.
- Reset takes priority over any walk or spawn in the same cycle. A walk interrupted by reset does not resume.
- All outputs except spawn_ready are registered. A write becomes visible on obstacles_out the cycle after the clock edge that performs it.
- Frame latency: trigger at cycle T. Slot i updates at edge T+1+i and is visible at T+2+i. frame_done is high during cycle T+1+NUM_SLOTS.
- Accepting a spawn takes one cycle. Back-to-back spawns are allowed on consecutive IDLE cycles, each filling the next lowest free slot.
- The free-slot search and the lane_blocked compare are combinational over NUM_SLOTS. They must close at 65 MHz.

## Test plan
- Reset, then spawn lane 1 type 2 -> slot 0 = {2, 1023, 1, 1}, active_count = 1, all other slots 0.
- Spawn lane 0, then spawn lane 0 again immediately -> second request held (ready = 0). With speed = 15, it is accepted after 11 frames, when position 858 < 863.
- Slot at position 5, speed = 7, frame_trigger -> slot 0 retired (active = 0, position 0), active_count decrements, frame_done at T+11.
- Fill all 10 slots across lanes 0..2 -> spawn_ready = 0. Retire slot 3, then spawn -> the new obstacle lands in slot 3.
- Second frame_trigger 4 cycles after the first -> frame_overrun = 1, and positions decrement exactly once.
- Assert game_reset mid-walk with 6 active slots -> next cycle all slots 0, active_count = 0, state IDLE, frame_overrun unchanged.
